// File: rtl/fib_scheduler.sv
// fib_scheduler: round-robin front end that shares one Fibonacci engine among
// NREQ requesters. One request is in flight at a time; out-of-range indices are
// answered with an error and never reach the engine. The engine start/busy
// handshake is sequenced here, and a watchdog turns a stuck engine into an
// error response.
module fib_scheduler #(
    parameter int NREQ      = 4,
    parameter int MAX_N     = 47,
    parameter int WD_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*32-1:0]      req_n,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_data,
    output logic                    rsp_err,
    output logic                    eng_start,
    output logic [31:0]             eng_n,
    input  logic [31:0]             eng_result,
    input  logic                    eng_busy,
    output logic [15:0]             done_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int SW  = IDW + 1;
    localparam int WDW = $clog2(WD_CYCLES + 1);

    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);
    localparam logic [SW-1:0]  NREQ_S  = SW'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [31:0]    MAX_N_V = 32'(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]     n_q, n_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [15:0]     done_q, done_d;

    // Rotated scan: offset gi looks at requester (rr_ptr + gi) mod NREQ.
    logic [SW-1:0]   scan_sum [NREQ];
    logic [IDW-1:0]  scan_idx [NREQ];
    logic [NREQ-1:0] scan_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_scan
            assign scan_sum[gi] = {1'b0, rr_ptr_q} + SW'(gi);
            assign scan_idx[gi] = (scan_sum[gi] >= NREQ_S) ?
                                  IDW'(scan_sum[gi] - NREQ_S) :
                                  scan_sum[gi][IDW-1:0];
            assign scan_hit[gi] = req_valid[scan_idx[gi]];
        end
    endgenerate

    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [31:0]    grant_n;

    // Pick the pending requester with the smallest rotated offset.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (scan_hit[k]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[k];
            end
        end
    end

    assign grant_n = req_n[{grant_idx, 5'd0} +: 32];

    // Next-state logic, grant pulse, engine start and response capture.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        n_d        = n_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        wd_d       = wd_q;
        done_d     = done_q;
        req_ready  = '0;
        eng_start  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A busy engine (e.g. still running after a timeout) defers the grant.
                if (grant_any && !eng_busy && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    n_d      = grant_n;
                    rsp_id_d = grant_idx;
                    rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                    wd_d     = '0;
                    if (grant_n > MAX_N_V) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'd0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                eng_start = 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // The engine must raise busy within two cycles of start.
                if (eng_busy) begin
                    wd_d    = '0;
                    state_d = S_WAIT_LO;
                end else if (wd_q != '0) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'd0;
                    state_d    = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!eng_busy) begin
                    rsp_data_d = eng_result;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'd0;
                    state_d    = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_d  = done_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            n_q        <= 32'd0;
            rsp_id_q   <= '0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            wd_q       <= '0;
            done_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            n_q        <= n_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
        end
    end

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign eng_n      = n_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_fib_scheduler.sv
// Self-checking bench for fib_scheduler with a behavioural Fibonacci engine stub.
module tb_fib_scheduler;

    localparam int NREQ      = 4;
    localparam int MAX_N     = 47;
    localparam int WD_CYCLES = 64;
    localparam int IDW       = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_n;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic                 eng_start;
    logic [31:0]          eng_n;
    logic [31:0]          eng_result;
    logic                 eng_busy;
    logic [15:0]          done_count;

    logic                 stub_stuck;
    logic                 stub_dead;
    logic [31:0]          stub_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fib_scheduler #(
        .NREQ(NREQ), .MAX_N(MAX_N), .WD_CYCLES(WD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_n(eng_n), .eng_result(eng_result),
        .eng_busy(eng_busy), .done_count(done_count)
    );

    // Reference Fibonacci: F(0)=0, F(1)=1.
    function automatic logic [31:0] fib(input logic [31:0] n);
        logic [31:0] a, b, t;
        a = 32'd0;
        b = 32'd1;
        if (n > 32'd47) return 32'd0;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine stand-in: busy for n+1 cycles after start; can be made stuck or deaf.
    always @(posedge clk) begin
        if (rst) begin
            eng_busy   <= 1'b0;
            stub_cnt   <= 32'd0;
            eng_result <= 32'd0;
        end else if (eng_start && !stub_dead) begin
            eng_busy   <= 1'b1;
            stub_cnt   <= eng_n;
            eng_result <= fib(eng_n);
        end else if (eng_busy) begin
            if (stub_stuck)            stub_cnt <= 32'd0;
            else if (stub_cnt == 32'd0) eng_busy <= 1'b0;
            else                        stub_cnt <= stub_cnt - 32'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one request and observe it; lat/start_lat are cycles after the grant cycle.
    task automatic do_request(input int id, input logic [31:0] n,
                              output bit granted, output int lat, output int start_lat,
                              output logic [31:0] start_n, output logic [IDW-1:0] oid,
                              output logic [31:0] odata, output logic oerr);
        granted = 1'b0; lat = -1; start_lat = -1; start_n = '0;
        oid = '0; odata = '0; oerr = 1'b0;
        tick();
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_n[32*id +: 32] = n;
        rsp_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                granted = 1'b1;
                break;
            end
            tick();
        end
        if (!granted) begin
            req_valid = '0;
            return;
        end
        for (int k = 1; k <= 200; k++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            if (eng_start && start_lat < 0) begin
                start_lat = k;
                start_n   = eng_n;
            end
            if (rsp_valid) begin
                lat = k; oid = rsp_id; odata = rsp_data; oerr = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        checks++; if (eng_n !== 32'd0) begin errors++; $display("FAIL reset_eng_n: got %0d want 0", eng_n); end
        checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL reset_done_count: got %0d want 0", done_count); end
    endtask

    task automatic test_single();
        bit g; int lat, slat; logic [31:0] sn, d; logic [IDW-1:0] id; logic e;
        do_request(1, 32'd10, g, lat, slat, sn, id, d, e);
        $display("single: req=1 n=10 granted=%0d start@+%0d rsp@+%0d id=%0d data=%0d err=%0d", g, slat, lat, id, d, e);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL single_grant: got %0d want 1", g); end
        checks++; if (slat !== 1) begin errors++; $display("FAIL single_start_lat: got %0d want 1", slat); end
        checks++; if (sn !== 32'd10) begin errors++; $display("FAIL single_eng_n: got %0d want 10", sn); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL single_rsp_lat: got %0d want 14", lat); end
        checks++; if (id !== IDW'(1) || d !== 32'd55 || e !== 1'b0) begin
            errors++; $display("FAIL single_rsp: got id=%0d data=%0d err=%0d want id=1 data=55 err=0", id, d, e);
        end
    endtask

    task automatic test_all_four();
        logic [31:0]     exp_data [NREQ];
        logic [31:0]     nval [NREQ];
        logic [NREQ-1:0] pend, exp_rdy;
        int ptr, nrsp, last_grant, last_n, g;
        exp_data = '{32'd1, 32'd2, 32'd3, 32'd5};
        nval     = '{32'd2, 32'd3, 32'd4, 32'd5};
        do_reset();
        tick();
        pend = '1;
        for (int i = 0; i < NREQ; i++) req_n[32*i +: 32] = nval[i];
        req_valid = pend;
        rsp_ready = 1'b1;
        ptr = 0; nrsp = 0; last_grant = -1; last_n = 0;
        for (int c = 0; c < 200 && nrsp < NREQ; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                exp_rdy = '0; g = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (pend[(ptr + k) % NREQ]) begin
                        g = (ptr + k) % NREQ;
                        exp_rdy[g] = 1'b1;
                        break;
                    end
                end
                $display("all4: grant mask=%b at cycle %0d", req_ready, c);
                checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL all4_grant: got %b want %b", req_ready, exp_rdy); end
                if (last_grant >= 0) begin
                    checks++; if (c - last_grant !== last_n + 5) begin
                        errors++; $display("FAIL all4_spacing: got %0d want %0d", c - last_grant, last_n + 5);
                    end
                end
                last_grant = c; last_n = int'(nval[g]); pend[g] = 1'b0; ptr = (g + 1) % NREQ;
            end
            if (rsp_valid) begin
                $display("all4: rsp id=%0d data=%0d err=%0d", rsp_id, rsp_data, rsp_err);
                checks++; if (rsp_id !== IDW'(nrsp) || rsp_data !== exp_data[nrsp] || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL all4_rsp: got id=%0d data=%0d err=%0d want id=%0d data=%0d err=0",
                                       rsp_id, rsp_data, rsp_err, nrsp, exp_data[nrsp]);
                end
                nrsp++;
            end
            tick();
            req_valid = pend;
        end
        req_valid = '0;
        checks++; if (nrsp !== NREQ) begin errors++; $display("FAIL all4_count: got %0d want %0d", nrsp, NREQ); end
        @(negedge clk);
        checks++; if (done_count !== 16'd4) begin errors++; $display("FAIL all4_done_count: got %0d want 4", done_count); end
    endtask

    task automatic test_range();
        bit g; int lat, slat; logic [31:0] sn, d; logic [IDW-1:0] id; logic e;
        do_request(2, 32'd48, g, lat, slat, sn, id, d, e);
        $display("range: req=2 n=48 rsp@+%0d id=%0d data=%0d err=%0d start@+%0d", lat, id, d, e, slat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL range_lat: got %0d want 1", lat); end
        checks++; if (id !== IDW'(2) || d !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL range_rsp: got id=%0d data=%0d err=%0d want id=2 data=0 err=1", id, d, e);
        end
        checks++; if (slat !== -1) begin errors++; $display("FAIL range_no_start: got start at +%0d want none", slat); end
        do_request(2, 32'd47, g, lat, slat, sn, id, d, e);
        $display("range: req=2 n=47 rsp@+%0d data=%0d err=%0d", lat, d, e);
        checks++; if (lat !== 51) begin errors++; $display("FAIL max_n_lat: got %0d want 51", lat); end
        checks++; if (d !== 32'd2971215073 || e !== 1'b0) begin
            errors++; $display("FAIL max_n_rsp: got data=%0d err=%0d want data=2971215073 err=0", d, e);
        end
    endtask

    task automatic test_backpressure();
        bit saw_grant, bad, got;
        do_reset();
        tick();
        req_n[0 +: 32]  = 32'd3;
        req_n[96 +: 32] = 32'd1;
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_grant: got %b want 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        saw_grant = 1'b0; got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready != '0) saw_grant = 1'b1;
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
        end
        checks++; if (!got) begin errors++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk);
            if (req_ready != '0) saw_grant = 1'b1;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(0) || rsp_data !== 32'd2 || rsp_err !== 1'b0) bad = 1'b1;
        end
        $display("bp: held 20 cycles id=%0d data=%0d err=%0d done=%0d", rsp_id, rsp_data, rsp_err, done_count);
        checks++; if (saw_grant) begin errors++; $display("FAIL bp_no_grant: got grant during stall want none"); end
        checks++; if (bad) begin errors++; $display("FAIL bp_stable: got changing rsp want id=0 data=2 err=0 valid=1"); end
        checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL bp_done_hold: got %0d want 0", done_count); end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_handshake_cycle: got %b want 0000", req_ready); end
        tick();
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
        checks++; if (done_count !== 16'd1) begin errors++; $display("FAIL bp_done_inc: got %0d want 1", done_count); end
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        checks++; if (!got || rsp_id !== IDW'(3) || rsp_data !== 32'd1) begin
            errors++; $display("FAIL bp_second_rsp: got valid=%0d id=%0d data=%0d want id=3 data=1", got, rsp_id, rsp_data);
        end
    endtask

    task automatic test_watchdog();
        bit g, saw; int lat, slat, k_grant; logic [31:0] sn, d; logic [IDW-1:0] id; logic e;
        do_reset();
        stub_dead = 1'b1;
        do_request(3, 32'd6, g, lat, slat, sn, id, d, e);
        stub_dead = 1'b0;
        $display("no_busy: req=3 n=6 rsp@+%0d id=%0d data=%0d err=%0d", lat, id, d, e);
        checks++; if (lat !== 4 || id !== IDW'(3) || d !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL hi_timeout: got lat=%0d id=%0d data=%0d err=%0d want lat=4 id=3 data=0 err=1", lat, id, d, e);
        end
        stub_stuck = 1'b1;
        do_request(1, 32'd5, g, lat, slat, sn, id, d, e);
        $display("stuck: req=1 n=5 start@+%0d rsp@+%0d id=%0d data=%0d err=%0d", slat, lat, id, d, e);
        checks++; if (slat !== 1) begin errors++; $display("FAIL wd_start: got %0d want 1", slat); end
        checks++; if (lat !== WD_CYCLES + 3 || id !== IDW'(1) || d !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL lo_timeout: got lat=%0d id=%0d data=%0d err=%0d want lat=%0d id=1 data=0 err=1",
                               lat, id, d, e, WD_CYCLES + 3);
        end
        tick();
        req_n[0 +: 32] = 32'd4;
        req_valid = 4'b0001;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready != '0) saw = 1'b1;
            tick();
        end
        checks++; if (saw) begin errors++; $display("FAIL wd_defer: got grant while engine busy want none"); end
        stub_stuck = 1'b0;
        k_grant = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin k_grant = k; break; end
            tick();
        end
        checks++; if (k_grant !== 1) begin errors++; $display("FAIL wd_release_grant: got %0d want 1", k_grant); end
        saw = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            if (rsp_valid) begin saw = 1'b1; break; end
        end
        checks++; if (!saw || rsp_data !== 32'd3 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL wd_recover: got valid=%0d data=%0d err=%0d want data=3 err=0", saw, rsp_data, rsp_err);
        end
    endtask

    task automatic test_reset_midflight();
        bit g; int lat, slat; logic [31:0] sn, d; logic [IDW-1:0] id; logic e;
        logic [NREQ+IDW+82:0] outs;
        tick();
        req_n[64 +: 32] = 32'd30;
        req_valid = 4'b0100;
        g = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[2]) begin g = 1'b1; break; end
            tick();
        end
        checks++; if (!g) begin errors++; $display("FAIL mid_grant: got no grant want grant"); end
        tick();
        req_valid = '0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        outs = {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_n, done_count};
        $display("mid_reset: outputs=%h", outs);
        checks++; if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
        do_request(2, 32'd0, g, lat, slat, sn, id, d, e);
        $display("after_reset: req=2 n=0 rsp@+%0d data=%0d err=%0d", lat, d, e);
        checks++; if (lat !== 4 || d !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL after_reset_n0: got lat=%0d data=%0d err=%0d want lat=4 data=0 err=0", lat, d, e);
        end
    endtask

    task automatic test_random();
        bit              vld [NREQ];
        logic [31:0]     nv  [NREQ];
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     exp_data, exp_n;
        logic            exp_err;
        bit              outstanding, seen_valid, hung;
        int ptr, g, exp_id, exp_lat, grant_cyc, exp_done, ntx;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin vld[i] = 1'b0; nv[i] = 32'd0; end
        ptr = 0; outstanding = 1'b0; exp_done = 0; ntx = 0; hung = 1'b0;
        exp_id = 0; exp_data = '0; exp_err = 1'b0; exp_n = '0; exp_lat = 0; grant_cyc = 0; seen_valid = 1'b0;
        for (int c = 0; c < 1500 && !hung; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (vld[i]) begin
                    if ($urandom_range(0, 15) == 0) vld[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    vld[i] = 1'b1;
                    nv[i]  = $urandom_range(0, 52);
                end
                req_valid[i] = vld[i];
                req_n[32*i +: 32] = nv[i];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = '0; g = -1;
            if (!outstanding && !eng_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (vld[(ptr + k) % NREQ]) begin
                        g = (ptr + k) % NREQ;
                        exp_rdy[g] = 1'b1;
                        break;
                    end
                end
            end
            checks++; if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_grant: cycle %0d got %b want %b", c, req_ready, exp_rdy);
            end
            if (g >= 0) begin
                outstanding = 1'b1; ptr = (g + 1) % NREQ; exp_id = g; exp_n = nv[g];
                exp_err  = (nv[g] > 32'(MAX_N));
                exp_data = exp_err ? 32'd0 : fib(nv[g]);
                exp_lat  = exp_err ? 1 : int'(nv[g]) + 4;
                grant_cyc = c; seen_valid = 1'b0; vld[g] = 1'b0;
            end else if (outstanding) begin
                if (eng_start) begin
                    checks++; if (c - grant_cyc !== 1 || eng_n !== exp_n) begin
                        errors++; $display("FAIL rand_start: got +%0d n=%0d want +1 n=%0d", c - grant_cyc, eng_n, exp_n);
                    end
                end
                if (rsp_valid) begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        $display("rand: id=%0d n=%0d rsp@+%0d data=%0d err=%0d", rsp_id, exp_n, c - grant_cyc, rsp_data, rsp_err);
                        checks++; if (c - grant_cyc !== exp_lat) begin
                            errors++; $display("FAIL rand_latency: got %0d want %0d", c - grant_cyc, exp_lat);
                        end
                    end
                    checks++; if (rsp_id !== IDW'(exp_id) || rsp_data !== exp_data || rsp_err !== exp_err) begin
                        errors++; $display("FAIL rand_rsp: got id=%0d data=%0d err=%0d want id=%0d data=%0d err=%0d",
                                           rsp_id, rsp_data, rsp_err, exp_id, exp_data, exp_err);
                    end
                    if (rsp_ready) begin
                        outstanding = 1'b0; exp_done++; ntx++;
                    end
                end else if (c - grant_cyc > 150) begin
                    hung = 1'b1;
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        checks++; if (hung) begin errors++; $display("FAIL rand_hang: got no response want response"); end
        tick();
        @(negedge clk);
        $display("rand: %0d transactions, done_count=%0d", ntx, done_count);
        checks++; if (done_count !== 16'(exp_done)) begin
            errors++; $display("FAIL rand_done_count: got %0d want %0d", done_count, exp_done);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_n      = '0;
        rsp_ready  = 1'b1;
        stub_stuck = 1'b0;
        stub_dead  = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_range();
        test_backpressure();
        test_watchdog();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fib_scheduler.md
# fib_scheduler

Round-robin scheduler that shares one Fibonacci engine (start/n/result/busy core) among NREQ requesters. Accepts one request at a time, rejects out-of-range indices without touching the engine, sequences the engine start/busy handshake, and returns each result with the originating requester ID on a single valid/ready response channel. It sits between the requester ports and the engine; the engine's clk/rst are driven from the same domain.

## Interface
- NREQ, 4: number of requesters, 2..8.
- MAX_N, 47: largest accepted index. F(47) is the largest Fibonacci value that fits in 32 bits.
- WD_CYCLES, 64: watchdog limit, in cycles, for the engine busy phase. Must be greater than MAX_N+2.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request pending.
- req_n  in  NREQ*32  per-requester index; slice i is bits [32*i+31:32*i].
- req_ready  out  NREQ  one-hot acceptance pulse.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  requester that issued the request.
- rsp_data  out  32  F(n), or 0 on error.
- rsp_err  out  1  1 means range error or watchdog timeout.
- eng_start  out  1  one-cycle engine start pulse.
- eng_n  out  32  index to the engine; held stable from start until the result is captured.
- eng_result  in  32  engine result.
- eng_busy  in  1  engine busy.
- done_count  out  16  count of responses consumed, wraps at 2^16.

## Operation
- States: IDLE, LAUNCH, WAIT_HI, WAIT_LO, RESP.
- IDLE
  - The grant goes to the first requester with req_valid set, scanning from rr_ptr upward modulo NREQ.
  - Granting requires eng_busy=0. If eng_busy=1, no grant is made.
  - In the grant cycle: req_ready[g]=1 (combinational), latch n and id, and set rr_ptr = g+1 mod NREQ.
  - If latched n > MAX_N: set rsp_err=1 and rsp_data=0, then go to RESP. The engine is not started.
  - Otherwise go to LAUNCH.
- LAUNCH
  - eng_start=1 for exactly this cycle; eng_n = latched n.
  - Go to WAIT_HI.
- WAIT_HI
  - If eng_busy=1, go to WAIT_LO.
  - If eng_busy is not seen within 2 cycles, it is a timeout: rsp_err=1, rsp_data=0, go to RESP.
- WAIT_LO
  - While eng_busy=1, increment the watchdog counter.
  - If eng_busy=0, capture rsp_data = eng_result, set rsp_err=0, go to RESP.
  - If the watchdog counter reaches WD_CYCLES, it is a timeout: rsp_err=1, rsp_data=0, go to RESP.
- RESP
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake: increment done_count, go to IDLE.
- Grant rules:
  - Only one request is outstanding at a time.
  - req_valid is not required to stay high; a requester that drops it before being granted is skipped.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, eng_start 0, eng_n 0, done_count 0.

## Timing
- Let T be the cycle in which req_ready[g]=1. Engine timing below is for the team's Fibonacci core.
  - eng_start=1 in T+1.
  - eng_busy=1 from T+2 through T+n+2.
  - WAIT_LO sees eng_busy=0 in T+n+3.
  - rsp_valid rises in T+n+4. So n=0 gives rsp_valid in T+4.
- Range error: rsp_valid rises in T+1.
- The earliest next grant is in the cycle after the RESP handshake. Throughput is one request per n+5 cycles with rsp_ready tied high.
- Simultaneous requests: strict round-robin. With all valid and rr_ptr=0, the grant order is 0,1,2,…,NREQ-1,0.
- rsp_ready held low: the FSM stays in RESP and other requesters are not granted (backpressure).
- rst in any state: all outputs return to their reset values on the next edge and any in-flight result is discarded.
  - The engine is reset by the same rst, so nothing is left running.
- eng_busy=1 while in IDLE (for example after a timeout): the grant is deferred until eng_busy=0.
- done_count wraps from 0xFFFF to 0x0000.

## Test plan
- Single request, req 1, n=10: req_ready[1] pulses at T, eng_start at T+1, rsp_valid at T+14 with rsp_id=1, rsp_data=55, rsp_err=0.
- All four requesters valid at once with n=2,3,4,5 for requesters 0,1,2,3 and rsp_ready=1: responses arrive in order id 0,1,2,3 with data 1,2,3,5. done_count=4 at the end.
- n=48 on requester 2: rsp_valid at T+1 with rsp_err=1, rsp_data=0; eng_start never asserted. Then n=47 on requester 2: rsp_data=2971215073.
- Backpressure: rsp_ready=0 for 20 cycles while requester 3 is pending. No req_ready[3] until the handshake; rsp fields stay stable throughout.
- Stub engine that holds busy high: after n=5 is granted, rsp_err=1 after WD_CYCLES cycles in WAIT_LO. No new grant until the stub drops busy.
- rst asserted in WAIT_LO with n=30: the next cycle shows all outputs at reset values. A following request with n=0 returns rsp_data=0, rsp_err=0 at T+4.
